// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-organised instruction store, combinational read
module instruction_memory #(
    parameter int BIT_WIDTH   = 32,
    parameter int ENTRY_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 write_enable,
    input  logic [BIT_WIDTH-1:0] write_address,
    input  logic [BIT_WIDTH-1:0] write_data,
    input  logic [BIT_WIDTH-1:0] read_address,
    output logic [BIT_WIDTH-1:0] read_data
);

    localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam logic [BIT_WIDTH-1:0] DEPTH = BIT_WIDTH'(ENTRY_COUNT);

    logic [BIT_WIDTH-1:0] mem [ENTRY_COUNT];
    logic [BIT_WIDTH-1:0] rd_word;
    logic [BIT_WIDTH-1:0] wr_word;

    assign rd_word = read_address >> 2;
    assign wr_word = write_address >> 2;

    always_ff @(posedge clk) begin
        if (write_enable && (wr_word < DEPTH)) begin
            mem[wr_word[IDX_W-1:0]] <= write_data;
        end
    end

    // Out-of-range reads return zero; the fetch stage never captures them.
    assign read_data = (rd_word < DEPTH) ? mem[rd_word[IDX_W-1:0]] : '0;

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with hold / +4 / redirect next-PC mux
module program_counter
    import riscv_pkg::*;
#(
    parameter int                   BIT_WIDTH = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  pc_sel_t              pc_sel,
    input  logic [BIT_WIDTH-1:0] redirect_target,
    output logic [BIT_WIDTH-1:0] pc,
    output logic [BIT_WIDTH-1:0] pc_plus4
);

    logic [BIT_WIDTH-1:0] pc_next;

    // Wraps modulo 2^BIT_WIDTH; the fetch stage's legality check catches the wrap.
    assign pc_plus4 = pc + BIT_WIDTH'(4);

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PC_INC:      pc_next = pc_plus4;
            PC_REDIRECT: pc_next = redirect_target;
            default:     pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, legality check, RUN/FAULT FSM, IF/ID register
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int                   BIT_WIDTH   = 32,
    parameter int                   ENTRY_COUNT = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [BIT_WIDTH-1:0] imem_addr,
    input  logic [BIT_WIDTH-1:0] imem_data,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [BIT_WIDTH-1:0] redirect_target,
    output logic                 if_id_valid,
    output logic [BIT_WIDTH-1:0] if_id_pc,
    output logic [BIT_WIDTH-1:0] if_id_instr,
    output logic [BIT_WIDTH-1:0] if_id_pc_plus4,
    output logic                 fetch_fault
);

    localparam logic [BIT_WIDTH-1:0] LAST_ADDR = BIT_WIDTH'(4 * ENTRY_COUNT - 4);
    localparam if_id_t IF_ID_RESET = '{valid: 1'b0, pc: '0, instr: NOP_INSTR, pc_plus4: '0};

    fetch_state_t         state, state_n;
    pc_sel_t              pc_sel;
    if_id_t               if_id_q, if_id_n;
    logic [BIT_WIDTH-1:0] pc, pc_plus4;
    logic                 pc_legal;

    program_counter #(
        .BIT_WIDTH (BIT_WIDTH),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clk             (clk),
        .rst             (rst),
        .pc_sel          (pc_sel),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4)
    );

    assign imem_addr = pc;
    assign pc_legal  = (pc[1:0] == 2'b00) && (pc <= LAST_ADDR);

    always_comb begin
        state_n = state;
        pc_sel  = PC_HOLD;
        if_id_n = if_id_q;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_sel        = PC_REDIRECT;
                    if_id_n.valid = 1'b0;
                    if_id_n.instr = NOP_INSTR;
                end else if (!pc_legal) begin
                    state_n       = FAULT;
                    if_id_n.valid = 1'b0;
                    if_id_n.instr = NOP_INSTR;
                end else if (!stall) begin
                    pc_sel  = PC_INC;
                    if_id_n = '{valid: 1'b1, pc: pc, instr: imem_data, pc_plus4: pc_plus4};
                end
            end
            FAULT: begin
                // Bubble is already in IF/ID; only a redirect leaves FAULT.
                if (redirect_valid) begin
                    pc_sel  = PC_REDIRECT;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            if_id_q <= IF_ID_RESET;
        end else begin
            state   <= state_n;
            if_id_q <= if_id_n;
        end
    end

    assign if_id_valid    = if_id_q.valid;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign fetch_fault    = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam int          BW  = 32;
    localparam int          EC  = 32;
    localparam logic [31:0] RPC = 32'h0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] imem_addr, imem_data;
    logic          stall, redirect_valid;
    logic [BW-1:0] redirect_target;
    logic          if_id_valid, fetch_fault;
    logic [BW-1:0] if_id_pc, if_id_instr, if_id_pc_plus4;
    logic          we;
    logic [BW-1:0] wa, wd;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc, m_ifpc, m_instr, m_p4;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    instruction_fetch #(.BIT_WIDTH(BW), .ENTRY_COUNT(EC), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .fetch_fault     (fetch_fault)
    );

    instruction_memory #(.BIT_WIDTH(BW), .ENTRY_COUNT(EC)) u_imem (
        .clk           (clk),
        .write_enable  (we),
        .write_address (wa),
        .write_data    (wd),
        .read_address  (imem_addr),
        .read_data     (imem_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 4 * EC - 4);
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_valid = 0; m_ifpc = 0; m_instr = NOP; m_p4 = 0; m_fault = 0;
    endtask

    // What the pipeline should look like after one edge with the given controls.
    task automatic model_step(input logic st, input logic rv, input logic [31:0] tg);
        if (m_fault) begin
            if (rv) begin m_pc = tg; m_fault = 0; end
        end else if (rv) begin
            m_pc = tg; m_valid = 0; m_instr = NOP;
        end else if (!addr_ok(m_pc)) begin
            m_fault = 1; m_valid = 0; m_instr = NOP;
        end else if (!st) begin
            m_valid = 1; m_ifpc = m_pc; m_instr = 32'h1000_0000 + m_pc / 4;
            m_p4 = m_pc + 4; m_pc = m_pc + 4;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
        check({tag, ".pc"}, if_id_pc, m_ifpc);
        check({tag, ".instr"}, if_id_instr, m_instr);
        check({tag, ".pc_plus4"}, if_id_pc_plus4, m_p4);
        check({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic tick(input string tag, input logic st, input logic rv, input logic [31:0] tg);
        stall = st; redirect_valid = rv; redirect_target = tg;
        model_step(st, rv, tg);
        @(posedge clk); #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
        we = 0; wa = 0; wd = 0;
        model_reset();
        for (int i = 0; i < EC; i++) begin
            @(negedge clk);
            we = 1; wa = 32'(i * 4); wd = 32'h1000_0000 + 32'(i);
        end
        @(negedge clk);
        we = 0;
        check_all("reset");
        rst = 0;

        for (int i = 0; i < 5; i++) tick("seq", 0, 0, 0);
        tick("redir8", 0, 1, 32'h8);
        tick("adv", 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("stall", 1, 0, 0);
        tick("post_stall", 0, 0, 0);
        tick("post_stall", 0, 0, 0);
        tick("redir_stall", 1, 1, 32'h40);
        tick("target", 0, 0, 0);
        tick("redir70", 0, 1, 32'h70);
        for (int i = 0; i < 4; i++) tick("to_end", 0, 0, 0);
        tick("oob_fault", 0, 0, 0);
        tick("fault_hold", 1, 0, 0);
        tick("fault_hold", 0, 0, 0);
        tick("fault_clr", 1, 1, 32'h0);
        tick("after_clr", 0, 0, 0);
        tick("redir_mis", 0, 1, 32'h6);
        tick("mis_fault", 0, 0, 0);
        tick("redir_ok", 0, 1, 32'h8);
        tick("resume", 0, 0, 0);
        tick("redir_wrap", 0, 1, 32'hFFFF_FFFC);
        tick("wrap_fault", 0, 0, 0);
        tick("wrap_clr", 0, 1, 32'h7C);
        tick("last_word", 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic        st, rv;
            logic [31:0] tg;
            int          kind;
            st   = ($urandom_range(0, 3) == 0);
            rv   = ($urandom_range(0, 9) == 0);
            kind = $urandom_range(0, 9);
            if (kind < 7)      tg = 32'($urandom_range(0, EC - 1) * 4);
            else if (kind < 9) tg = 32'($urandom_range(0, 4 * EC + 8));
            else               tg = $urandom;
            tick("rand", st, rv, tg);
        end

        // Asynchronous reset between edges.
        #2 rst = 1;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 0;
        tick("post_rst", 0, 0, 0);
        tick("post_rst", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage driving `instruction_memory`. Owns the program counter, presents the byte address to the combinational instruction memory, and captures the returned word into an IF/ID pipeline register for decode. Supports stall, redirect (branch/jump/flush) and detection of out-of-range or misaligned fetch addresses.

## Interface
Parameters:
- `BIT_WIDTH`, 32, width of PC, address and instruction word
- `ENTRY_COUNT`, 32, number of words in instruction memory; legal byte addresses are 0 .. 4*ENTRY_COUNT-4
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-high, `rst`.
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous active-high reset
- `imem_addr`  out  BIT_WIDTH  byte address to instruction_memory `read_address`; equals PC
- `imem_data`  in  BIT_WIDTH  word from instruction_memory `read_data`, valid same cycle
- `stall`  in  1  hold PC and IF/ID contents
- `redirect_valid`  in  1  load PC from `redirect_target`, flush IF/ID
- `redirect_target`  in  BIT_WIDTH  new byte address
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_pc`  out  BIT_WIDTH  address of captured instruction
- `if_id_instr`  out  BIT_WIDTH  captured instruction; NOP when invalid
- `if_id_pc_plus4`  out  BIT_WIDTH  `if_id_pc` + 4
- `fetch_fault`  out  1  fetch FSM in FAULT state

## Operation
- FSM states: RUN, FAULT. Reset -> RUN.
- Reset values: PC = RESET_PC, `if_id_valid` 0, `if_id_pc` 0, `if_id_instr` NOP (32'h00000013), `if_id_pc_plus4` 0, `fetch_fault` 0.
- `imem_addr` = PC combinationally in both states.
- Legal address: low two bits 0 and address <= 4*ENTRY_COUNT-4 (unsigned).
- Priority per edge: redirect > fault check > stall > advance.
- RUN, redirect_valid: PC <= target; IF/ID <= bubble (valid 0, instr NOP, pc/pc_plus4 hold). Stall ignored.
- RUN, no redirect, PC illegal: -> FAULT; IF/ID <= bubble; PC holds.
- RUN, stall, PC legal: PC and IF/ID hold.
- RUN, advance: IF/ID <= {valid 1, PC, imem_data, PC+4}; PC <= PC+4.
- FAULT: PC and IF/ID (bubble) hold; stall ignored; `fetch_fault` 1. redirect_valid -> PC <= target, -> RUN (a still-illegal target re-enters FAULT next edge).
- PC+4 is modulo 2^BIT_WIDTH; an overflow wrap lands past the legal range only via fault detection, never silently.
- Illegal redirect targets are accepted into PC; detection happens on the following edge.

## Timing
- Fetch latency 1: instruction at PC at edge N is on `if_id_*` after edge N.
- Redirect sampled at edge N: bubble after N, target instruction on IF/ID after N+1 (one-cycle penalty).
- Stall asserted at edge N: outputs after N equal outputs before N; stall for K cycles holds K cycles, no instruction lost or duplicated.
- Redirect and stall same edge: redirect wins, bubble inserted.
- `fetch_fault` asserts after the edge that samples an illegal PC; deasserts after the edge that samples redirect_valid.
- Reset asserted mid-run: all outputs to reset values immediately (async), no edge required; first valid IF/ID one edge after reset release.

## Structure
- Shared package `riscv_pkg`: `NOP_INSTR` constant (32'h00000013), `fetch_state_t` enum {RUN, FAULT}, `if_id_t` packed struct {valid, pc, instr, pc_plus4}.
- One sub-module: `program_counter` (PC register, next-PC mux: hold / +4 / redirect target, async reset to RESET_PC). FSM, legality check and IF/ID register live in `instruction_fetch`.
- Bench instantiates `instruction_fetch` and `instruction_memory` together, memory preloaded with word i = 32'h1000_0000 + i.

## Test plan
- Reset release, no stall/redirect, 5 edges -> IF/ID pc 0,4,8,12,16 with instr 10000000..10000004, valid 1 from first edge.
- Stall high for 3 edges at PC 8 -> IF/ID holds pc 4/instr 10000001; after release pc 8 then 12 follow, nothing skipped.
- Redirect to 0x40 at PC 12, stall also high -> bubble (valid 0, NOP), then pc 0x40/instr 10000010.
- Run sequentially to PC 0x7C then one more edge -> PC 0x80 illegal, `fetch_fault` 1, IF/ID bubble held; redirect to 0 -> fault clears, pc 0 fetched next.
- Redirect to 0x6 -> FAULT next edge; redirect to 0x8 -> RUN, pc 8/instr 10000002.
- Assert rst between edges mid-run -> all outputs reset values immediately, PC = RESET_PC.
